// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, widths, defaults.
package mem_pkg;

   localparam int DATA_W    = 32;
   localparam int CNT_W     = 4;
   localparam int DEPTH_DEF = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read (read-before-write on a shared address).
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // No reset: array contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder: accepts one access in IDLE, completes it with a Ready pulse.
// Optional MISALIGN_CHECK_EN: treat Addr[1:0]!=0 as a faulted access.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH       = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       Addr,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   output logic              Ready,
   output logic              Busy,
   output logic              Err
);

   localparam int               AW         = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LD    = CNT_W'(WAIT_CYCLES);
   localparam logic [31:0]      ADDR_LIMIT = 32'(DEPTH * 4);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                fault_q, fault_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                req_fault;
   logic                misalign;
   logic [AW-1:0]       ram_addr;
   logic                ram_we;
   logic [DATA_W-1:0]   ram_rdata;

`ifdef MISALIGN_CHECK_EN
   assign misalign = (Addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Both strobes high is a fault of its own: it neither reads nor writes.
   assign req_fault = (MemRead & MemWrite) | (Addr >= ADDR_LIMIT) | misalign;

   // The RAM reads the live address on the accept edge so data is ready even with zero wait states.
   assign ram_addr = (state_q == IDLE) ? Addr[AW+1:2] : addr_q;
   assign ram_we   = (state_q == DONE) & wr_q & ~fault_q & ~reset;

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (MemRead | MemWrite) begin
               addr_d  = Addr[AW+1:2];
               wdata_d = WriteData;
               rd_d    = MemRead & ~MemWrite;
               wr_d    = MemWrite & ~MemRead;
               fault_d = req_fault;
               if (WAIT_CYCLES == 0) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (rd_q) begin
               rdata_d = fault_q ? '0 : ram_rdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   // A reset arriving in the DONE cycle suppresses the completion pulse as well as the write.
   assign Ready    = (state_q == DONE) & ~reset;
   assign Err      = Ready & fault_q;
   assign Busy     = (state_q != IDLE);
   assign ReadData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses 2 wait states, instance 1 uses none.
module tb_data_mem_responder;

   localparam int LAT_A = 3;  // Ready 3 cycles after accept with WAIT_CYCLES=2
   localparam int LAT_B = 1;  // Ready 1 cycle after accept with WAIT_CYCLES=0

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        mem_read  [2];
   logic        mem_write [2];
   logic [31:0] addr      [2];
   logic [31:0] wdata     [2];
   logic [31:0] rdata     [2];
   logic        ready     [2];
   logic        busy      [2];
   logic        err       [2];

   data_mem_responder #(.WAIT_CYCLES(2), .DEPTH(64)) dut_a (
      .clk(clk), .reset(rst[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
      .Addr(addr[0]), .WriteData(wdata[0]), .ReadData(rdata[0]),
      .Ready(ready[0]), .Busy(busy[0]), .Err(err[0])
   );

   data_mem_responder #(.WAIT_CYCLES(0), .DEPTH(64)) dut_b (
      .clk(clk), .reset(rst[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
      .Addr(addr[1]), .WriteData(wdata[1]), .ReadData(rdata[1]),
      .Ready(ready[1]), .Busy(busy[1]), .Err(err[1])
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          acc;
      int          lat;
      logic        err;
      logic        chk;
      logic [31:0] rd;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q1[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drop(input int d);
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
      addr[d]      = 32'h0;
      wdata[d]     = 32'h0;
   endtask

   task automatic mon(input int d);
      logic        pend;
      logic [31:0] pend_val;
      exp_t        e;
      int          qsz;
      pend = 1'b0;
      pend_val = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check($sformatf("read_data_dut%0d", d), rdata[d], pend_val);
            pend = 1'b0;
         end
         if (err[d] && !ready[d]) begin
            n_checks++;
            $display("FAIL err_without_ready dut%0d: Err=1 Ready=0 at cycle %0d", d, cyc);
         end
         if (ready[d]) begin
            qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
            if (qsz == 0) begin
               n_checks++;
               $display("FAIL unexpected_ready dut%0d: Ready=1 with nothing pending at cycle %0d", d, cyc);
            end else begin
               if (d == 0) e = exp_q0.pop_front();
               else        e = exp_q1.pop_front();
               check($sformatf("latency_dut%0d", d), 32'(cyc - e.acc + 1), 32'(e.lat));
               check($sformatf("err_dut%0d", d), {31'b0, err[d]}, {31'b0, e.err});
               if (e.chk) begin
                  pend     = 1'b1;
                  pend_val = e.rd;
               end
            end
         end
      end
   endtask

   initial mon(0);
   initial mon(1);

   // Issue one access; swap=1 keeps a different request on the pins while busy.
   task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic chk,
                         input logic [31:0] e_rd, input logic swap, output int acc);
      exp_t e;
      logic done;
      @(negedge clk);
      mem_read[d]  = rd;
      mem_write[d] = wr;
      addr[d]      = a;
      wdata[d]     = wd;
      @(posedge clk);
      #1;
      acc   = cyc;
      e.acc = acc;
      e.lat = (d == 0) ? LAT_A : LAT_B;
      e.err = e_err;
      e.chk = chk;
      e.rd  = e_rd;
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      @(negedge clk);
      check($sformatf("busy_in_flight_dut%0d", d), {31'b0, busy[d]}, 32'h1);
      done = 1'b0;
      if (ready[d]) begin
         drop(d);
         done = 1'b1;
      end else if (swap) begin
         mem_read[d]  = 1'b0;
         mem_write[d] = 1'b1;
         wdata[d]     = 32'h0BADF00D;
      end else begin
         drop(d);
      end
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (ready[d]) begin
            drop(d);
            done = 1'b1;
         end
      end
      if (!done) begin
         n_checks++;
         $display("FAIL ready_timeout dut%0d: no Ready within 40 cycles, required one", d);
         drop(d);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         drop(d);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_read_data_dut%0d", d), rdata[d], 32'h0);
         check($sformatf("reset_ready_dut%0d", d), {31'b0, ready[d]}, 32'h0);
         check($sformatf("reset_busy_dut%0d", d), {31'b0, busy[d]}, 32'h0);
         check($sformatf("reset_err_dut%0d", d), {31'b0, err[d]}, 32'h0);
      end

      // Zero wait states: read of an unwritten word, then write/read of word 1, accepts 2 cycles apart.
      access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      access(1, 1'b0, 1'b1, 32'h4, 32'h44444444, 1'b0, 1'b0, 32'h0, 1'b0, a1);
      access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'h44444444, 1'b0, a2);
      check("b2b_accept_gap_1", 32'(a1 - a0), 32'd2);
      check("b2b_accept_gap_2", 32'(a2 - a1), 32'd2);

      // Two wait states: basic write then read.
      access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, a0);

      // Both strobes: fault, ReadData keeps DEADBEEF, word 0x20 keeps its value.
      access(0, 1'b0, 1'b1, 32'h20, 32'h55AA00FF, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      access(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, a0);
      access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h55AA00FF, 1'b0, a0);

      // Out of range: read yields 0, write to 0x100 must not alias onto word 0.
      access(0, 1'b0, 1'b1, 32'h0, 32'h11110000, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      access(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, a0);
      access(0, 1'b0, 1'b1, 32'h100, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0, 1'b0, a0);
      access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11110000, 1'b0, a0);

      // Misaligned byte address.
`ifdef MISALIGN_CHECK_EN
      access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, a0);
`else
      access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, a0);
`endif

      // A write request waved while busy must be ignored.
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, a0);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, a0);

      // Back-to-back read/write of one word in program order.
      access(0, 1'b0, 1'b1, 32'h24, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, a0);
      access(0, 1'b0, 1'b1, 32'h24, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, a0);

      // Reset one cycle after accepting a write aborts it.
      access(0, 1'b0, 1'b1, 32'h8, 32'hCAFE0008, 1'b0, 1'b0, 32'h0, 1'b0, a0);
      @(negedge clk);
      mem_write[0] = 1'b1;
      addr[0]      = 32'h8;
      wdata[0]     = 32'h1234;
      @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b1;
      drop(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      check("abort_busy", {31'b0, busy[0]}, 32'h0);
      check("abort_read_data", rdata[0], 32'h0);
      access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'hCAFE0008, 1'b0, a0);

      repeat (5) @(negedge clk);
      check("pending_dut0", 32'(exp_q0.size()), 32'd0);
      check("pending_dut1", 32'(exp_q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
